rc_servo_on_timer: RTL and testbench
====================================

// Module: rc_servo_on_timer
// PURPOSE
//  Datapath partner of the RC servo channel FSM: holds the per-channel pulse ON-time,
//  times the ON phase and drives the servo output pin. Consumes load_RC_servo_ON_timer
//  and RC_servo_ON/RC_servo_OFF; returns ON_time_complete to the FSM. ON-time updates
//  are double-buffered so a new setting takes effect only at a servo period boundary.
// PARAMETERS
//  T_WIDTH     16    width of ON-time value and down-counter (ON-time in ticks)
//  PRESCALE    50    clk cycles per tick (1 us at 50 MHz); >=1
//  MIN_ON      1000  lower clamp in ticks (used only with RC_SERVO_CLAMP_EN)
//  MAX_ON      2000  upper clamp in ticks (used only with RC_SERVO_CLAMP_EN)
//  DEFAULT_ON  1500  reset value of staging and active ON-time (servo centre)
// PORTS
//  clk                     in   1        system clock, all flops rising edge
//  reset                   in   1        asynchronous, active-low reset
//  RC_on_time_wr           in   1        write strobe for staging ON-time register
//  RC_on_time_data         in   T_WIDTH  new ON-time in ticks
//  RC_servo_period_0       in   1        1-cycle pulse at start of each servo period
//  load_RC_servo_ON_timer  in   1        from FSM: load down-counter from active ON-time
//  RC_servo_ON             in   1        from FSM: ON phase in progress
//  RC_servo_OFF            in   1        from FSM: OFF phase
//  ON_time_complete        out  1        to FSM: last cycle of ON phase (combinational)
//  RC_servo_pin            out  1        servo PWM output (registered)
//  RC_update_pending       out  1        staging holds a value not yet transferred
//  RC_active_on_time       out  T_WIDTH  ON-time currently used for pulses
// BEHAVIOUR
//  Reset (async, reset==0): staging=active=DEFAULT_ON, pending=0, count=0, prescale=0,
//   RC_servo_pin=0. ON_time_complete=0 since FSM holds RC_servo_ON=0 in reset.
//  Staging: RC_on_time_wr -> staging<=RC_on_time_data, pending<=1 next edge.
//  Transfer: RC_servo_period_0 && pending -> active<=xfer(staging), pending<=0.
//   Simultaneous wr + period_0: transfer uses pre-write staging; new data stored,
//   pending stays 1 (applied next period). wr + period_0 with pending=0: no transfer,
//   pending<=1.
//  xfer(): raw value, except 0 is forced to 1 (guarantees non-zero pulse).
//  Mid-pulse writes/transfers never alter the pulse in progress (count already loaded).
//  Timer: load_RC_servo_ON_timer -> count<=active, prescale<=0.
//   While RC_servo_ON: prescale increments, wraps at PRESCALE-1; tick=(prescale==PRESCALE-1).
//   On tick with count>1: count<=count-1. Counter holds when RC_servo_ON=0.
//  ON_time_complete = RC_servo_ON && tick && (count<=1). With the FSM's 1-cycle ON state
//   exit, RC_servo_ON lasts exactly active*PRESCALE cycles.
//  Safety: RC_servo_ON with count==0 (no prior load) -> complete on first tick.
//  Pin: RC_servo_pin <= RC_servo_ON; cleared when RC_servo_OFF. One cycle latency,
//   width exactly active*PRESCALE cycles. RC_servo_ON and RC_servo_OFF never both 1.
//  Reset mid-pulse: pin drops immediately (async); active returns to DEFAULT_ON.
//  Status: RC_update_pending=pending; RC_active_on_time=active (registered values).
// CONFIGURATION
//  RC_SERVO_CLAMP_EN defined: xfer() saturates staging to [MIN_ON, MAX_ON] before
//   writing active; RC_active_on_time always within range.
//  RC_SERVO_CLAMP_EN undefined: no clamping; only the 0->1 rule applies; MIN_ON/MAX_ON
//   unused.
// TESTING
//  Reset, PRESCALE=1, load then ON -> pin high exactly 1500 cycles, complete pulses once.
//  wr 1200 mid-period -> pending=1, active stays 1500; at period_0 active=1200, pending=0.
//  wr 1800 same cycle as period_0 with staging 1200 pending -> active=1200, pending=1.
//  CLAMP_EN: wr 500 -> active 1000; wr 3000 -> 2000. No CLAMP_EN: wr 0 -> active 1.
//  PRESCALE=50, active=3 -> RC_servo_ON lasts 150 cycles, pin 150 cycles, 1-cycle lag.
//  reset asserted mid-pulse -> pin 0 immediately; after release active=1500, pending=0.

Source files
------------

// File: rtl/rc_servo_on_timer.sv
// RC servo ON-time datapath: double-buffered ON-time, prescaled down-counter, servo pin.
// Optional saturation of transferred ON-time to [MIN_ON, MAX_ON] with RC_SERVO_CLAMP_EN.
module rc_servo_on_timer #(
   parameter int T_WIDTH    = 16,
   parameter int PRESCALE   = 50,
   parameter int MIN_ON     = 1000,
   parameter int MAX_ON     = 2000,
   parameter int DEFAULT_ON = 1500
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               RC_on_time_wr,
   input  logic [T_WIDTH-1:0] RC_on_time_data,
   input  logic               RC_servo_period_0,
   input  logic               load_RC_servo_ON_timer,
   input  logic               RC_servo_ON,
   input  logic               RC_servo_OFF,
   output logic               ON_time_complete,
   output logic               RC_servo_pin,
   output logic               RC_update_pending,
   output logic [T_WIDTH-1:0] RC_active_on_time
);

`ifdef RC_SERVO_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]      PS_MAX = PW'(PRESCALE - 1);
   localparam logic [T_WIDTH-1:0] DEF    = T_WIDTH'(DEFAULT_ON);
   localparam logic [T_WIDTH-1:0] ONE    = T_WIDTH'(1);
   // Without clamping the window is [1, max] so only the zero->one rule bites.
   localparam logic [T_WIDTH-1:0] LO = CLAMP ? ((MIN_ON < 1) ? ONE : T_WIDTH'(MIN_ON)) : ONE;
   localparam logic [T_WIDTH-1:0] HI = CLAMP ? T_WIDTH'(MAX_ON) : '1;

   logic [T_WIDTH-1:0] staging, active, count, xfer_val;
   logic               pending;
   logic [PW-1:0]      prescale;
   logic               tick;

   always_comb begin
      xfer_val = staging;
      if (staging < LO)
         xfer_val = LO;
      else if (staging > HI)
         xfer_val = HI;
   end

   // A write coinciding with period_0 loses nothing: the old staging value
   // transfers and the new one stays pending for the next period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         staging <= DEF;
         active  <= DEF;
         pending <= 1'b0;
      end else begin
         if (RC_servo_period_0 && pending)
            active <= xfer_val;
         if (RC_on_time_wr) begin
            staging <= RC_on_time_data;
            pending <= 1'b1;
         end else if (RC_servo_period_0) begin
            pending <= 1'b0;
         end
      end
   end

   assign tick = (prescale == PS_MAX);

   // Count floors at 1 so complete fires on the active-th tick; an unloaded
   // count of 0 also completes on the first tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         prescale <= '0;
      end else if (load_RC_servo_ON_timer) begin
         count    <= active;
         prescale <= '0;
      end else if (RC_servo_ON) begin
         prescale <= tick ? '0 : prescale + 1'b1;
         if (tick && (count > ONE))
            count <= count - ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         RC_servo_pin <= 1'b0;
      else
         RC_servo_pin <= RC_servo_ON && !RC_servo_OFF;
   end

   assign ON_time_complete  = RC_servo_ON && tick && (count <= ONE);
   assign RC_update_pending = pending;
   assign RC_active_on_time = active;

endmodule

// File: tb/tb_rc_servo_on_timer.sv
// Bench for rc_servo_on_timer: two instances (PRESCALE 1 and 50) share inputs; the
// bench plays the channel FSM and keeps a transaction-level model of the ON-time buffer.
module tb_rc_servo_on_timer;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst_n, wr, p0, load, on, off;
   logic [TW-1:0] data;
   logic          comp, pin, pend, comp50, pin50, pend50;
   logic [TW-1:0] act, act50;

   int checks = 0;
   int errors = 0;

   int m_stage, m_active;
   bit m_pend;

   typedef struct {
      bit wr;
      int data;
      bit p0;
      bit exp_pend;
      int exp_act;
   } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   rc_servo_on_timer #(.T_WIDTH(TW), .PRESCALE(1)) dut (
      .clk(clk), .reset(rst_n), .RC_on_time_wr(wr), .RC_on_time_data(data),
      .RC_servo_period_0(p0), .load_RC_servo_ON_timer(load), .RC_servo_ON(on),
      .RC_servo_OFF(off), .ON_time_complete(comp), .RC_servo_pin(pin),
      .RC_update_pending(pend), .RC_active_on_time(act));

   rc_servo_on_timer #(.T_WIDTH(TW), .PRESCALE(50)) dut50 (
      .clk(clk), .reset(rst_n), .RC_on_time_wr(wr), .RC_on_time_data(data),
      .RC_servo_period_0(p0), .load_RC_servo_ON_timer(load), .RC_servo_ON(on),
      .RC_servo_OFF(off), .ON_time_complete(comp50), .RC_servo_pin(pin50),
      .RC_update_pending(pend50), .RC_active_on_time(act50));

   function automatic int xfer_m(input int raw);
`ifdef RC_SERVO_CLAMP_EN
      if (raw < 1000) return 1000;
      if (raw > 2000) return 2000;
      return raw;
`else
      return (raw == 0) ? 1 : raw;
`endif
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_stage = 1500; m_active = 1500; m_pend = 0;
   endtask

   // One clock: the model sees the inputs the DUT samples at this edge.
   task automatic step();
      @(posedge clk);
      if (p0 && m_pend) begin
         m_active = xfer_m(m_stage);
         m_pend   = 0;
      end
      if (wr) begin
         m_stage = int'(data);
         m_pend  = 1;
      end
      #1;
   endtask

   task automatic set_on_time(input int v);
      wr = 1; data = TW'(v); step();
      wr = 0; p0 = 1; step();
      p0 = 0;
   endtask

   // Plays the FSM: load, hold ON until complete, then one OFF cycle window.
   task automatic run_pulse(input bit use50, input int exp_len, input string tag);
      int on_len, pin_len;
      bit done, first_pin, c, p;
      on_len = 0; pin_len = 0; done = 0; first_pin = 0;
      load = 1; step();
      load = 0; on = 1; off = 0;
      while (!done && on_len < exp_len + 20) begin
         @(negedge clk);
         c = use50 ? comp50 : comp;
         p = use50 ? pin50 : pin;
         if (on_len == 0) first_pin = p;
         if (p) pin_len++;
         on_len++;
         if (c) done = 1;
         step();
      end
      on = 0; off = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         p = use50 ? pin50 : pin;
         if (p) pin_len++;
         if (i == 0) chk({tag, "_comp_after"}, int'(use50 ? comp50 : comp), 0);
         step();
      end
      off = 0;
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_on_len"}, on_len, exp_len);
      chk({tag, "_pin_len"}, pin_len, exp_len);
      chk({tag, "_pin_lag"}, int'(first_pin), 0);
   endtask

   initial begin
      rst_n = 0; wr = 0; p0 = 0; load = 0; on = 0; off = 0; data = '0;
      model_reset();
      #22;
      chk("rst_pin", int'(pin), 0);
      chk("rst_pend", int'(pend), 0);
      chk("rst_act", int'(act), 1500);
      chk("rst_act50", int'(act50), 1500);
      chk("rst_comp", int'(comp), 0);
      @(posedge clk); #1;
      rst_n = 1;
      step();

      // Unloaded count completes on the first tick.
      on = 1;
      @(negedge clk);
      chk("safety_comp", int'(comp), 1);
      chk("safety_comp50", int'(comp50), 0);
      step();
      on = 0;
      step();

      run_pulse(0, 1500, "p1_default");

      tbl[0]  = '{1, 1200, 0, 1, xfer_m(1500)};
      tbl[1]  = '{0, 0,    0, 1, xfer_m(1500)};
      tbl[2]  = '{0, 0,    1, 0, xfer_m(1200)};
      tbl[3]  = '{1, 1200, 0, 1, xfer_m(1200)};
      tbl[4]  = '{1, 1800, 1, 1, xfer_m(1200)};
      tbl[5]  = '{0, 0,    1, 0, xfer_m(1800)};
      tbl[6]  = '{1, 0,    0, 1, xfer_m(1800)};
      tbl[7]  = '{0, 0,    1, 0, xfer_m(0)};
      tbl[8]  = '{1, 77,   1, 1, xfer_m(0)};
      tbl[9]  = '{0, 0,    1, 0, xfer_m(77)};
      tbl[10] = '{0, 0,    1, 0, xfer_m(77)};
      tbl[11] = '{1, 3,    0, 1, xfer_m(77)};
      tbl[12] = '{0, 0,    1, 0, xfer_m(3)};
      for (int i = 0; i < 13; i++) begin
         wr = tbl[i].wr; data = TW'(tbl[i].data); p0 = tbl[i].p0;
         step();
         chk($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].exp_pend));
         chk($sformatf("tbl%0d_act", i), int'(act), tbl[i].exp_act);
      end
      wr = 0; p0 = 0;

      run_pulse(1, xfer_m(3) * 50, "p50_three");

      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 2) == 0);
         p0 = ($urandom_range(0, 3) == 0);
         data = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom);
         step();
         if (pend != m_pend || int'(act) != m_active || int'(act50) != m_active) begin
            chk($sformatf("rnd%0d_pend", i), int'(pend), int'(m_pend));
            chk($sformatf("rnd%0d_act", i), int'(act), m_active);
            chk($sformatf("rnd%0d_act50", i), int'(act50), m_active);
         end else begin
            checks++;
         end
      end
      wr = 0; p0 = 0;

      for (int i = 0; i < 4; i++) begin
         set_on_time(int'($urandom_range(1, 40)));
         chk($sformatf("rp%0d_act", i), int'(act), m_active);
         run_pulse(0, m_active, $sformatf("rp%0d", i));
         set_on_time(int'($urandom_range(1, 6)));
         run_pulse(1, m_active * 50, $sformatf("rq%0d", i));
      end

      // Asynchronous reset in the middle of a pulse.
      set_on_time(900);
      wr = 1; data = TW'(1100); step(); wr = 0;
      load = 1; step(); load = 0; on = 1;
      for (int i = 0; i < 20; i++) step();
      @(negedge clk);
      chk("midrst_pin_before", int'(pin), 1);
      #2 rst_n = 0;
      #1;
      chk("midrst_pin", int'(pin), 0);
      chk("midrst_pin50", int'(pin50), 0);
      chk("midrst_act", int'(act), 1500);
      on = 0;
      model_reset();
      step();
      rst_n = 1;
      step(); step();
      chk("post_rst_act", int'(act), m_active);
      chk("post_rst_pend", int'(pend), int'(m_pend));
      chk("post_rst_pend50", int'(pend50), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
